// File: rtl/mawb_pkg.sv
// Shared definitions for the memory-access / write-back stage: request bus
// field offsets, total bus width and the stage FSM state type.
package mawb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MEM  = 1'b1
   } mawb_state_e;

   // Request bus, LSB first: address, value, reg_addr, isLoad, isMemWrite, isWrite.
   function automatic int bus_width(input int addr_w, input int data_w, input int reg_aw);
      return addr_w + data_w + reg_aw + 3;
   endfunction

   function automatic int value_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int reg_lsb(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction

   function automatic int load_bit(input int addr_w, input int data_w, input int reg_aw);
      return addr_w + data_w + reg_aw;
   endfunction

   function automatic int memw_bit(input int addr_w, input int data_w, input int reg_aw);
      return addr_w + data_w + reg_aw + 1;
   endfunction

   function automatic int wr_bit(input int addr_w, input int data_w, input int reg_aw);
      return addr_w + data_w + reg_aw + 2;
   endfunction

endpackage

// File: rtl/mawb_data_mem.sv
// Data memory for the stage: synchronous write, combinational read, no reset
// so contents survive a stage reset.
module mawb_data_mem #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 64,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Combined memory-access and write-back stage with configurable access
// latency, internal data memory, load hazard tracking and a retire counter.
module mem_wb_stage
   import mawb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 64,
   parameter int REG_AW      = 4,
   parameter int DEPTH       = 256,
   parameter int MEM_LATENCY = 1,
   parameter int ZERO_REG    = 0,
   parameter int CNT_W       = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [bus_width(ADDR_W, DATA_W, REG_AW)-1:0] in_bus,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   output logic                                      rf_we,
   output logic [REG_AW-1:0]                         rf_waddr,
   output logic [DATA_W-1:0]                         rf_wdata,
   output logic                                      pend_valid,
   output logic [REG_AW-1:0]                         pend_addr,
   output logic                                      err,
   output logic [CNT_W-1:0]                          retired
);

   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int OFF_VAL  = value_lsb(ADDR_W);
   localparam int OFF_REG  = reg_lsb(ADDR_W, DATA_W);
   localparam int OFF_LOAD = load_bit(ADDR_W, DATA_W, REG_AW);
   localparam int OFF_MEMW = memw_bit(ADDR_W, DATA_W, REG_AW);
   localparam int OFF_WR   = wr_bit(ADDR_W, DATA_W, REG_AW);

   // Request field decode
   logic [ADDR_W-1:0] req_addr;
   logic [IDX_W-1:0]  req_idx;
   logic [DATA_W-1:0] req_value;
   logic [REG_AW-1:0] req_reg;
   logic              req_load, req_memw, req_wr;
   logic              req_is_load, req_is_store, req_is_mem;

   assign req_addr     = in_bus[ADDR_W-1:0];
   assign req_idx      = req_addr[IDX_W-1:0];
   assign req_value    = in_bus[OFF_VAL +: DATA_W];
   assign req_reg      = in_bus[OFF_REG +: REG_AW];
   assign req_load     = in_bus[OFF_LOAD];
   assign req_memw     = in_bus[OFF_MEMW];
   assign req_wr       = in_bus[OFF_WR];
   // An illegal load+store request is executed as a plain load.
   assign req_is_load  = req_load;
   assign req_is_store = req_memw && !req_load;
   assign req_is_mem   = req_load || req_memw;

   mawb_state_e       state_q, state_d;
   logic [LAT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic [REG_AW-1:0] reg_q, reg_d;
   logic              load_q, load_d;
   logic              store_q, store_d;
   logic              wr_q, wr_d;

   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              pend_valid_q, pend_valid_d;
   logic [REG_AW-1:0] pend_addr_q, pend_addr_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic              accept;
   logic              done;
   logic [IDX_W-1:0]  cur_idx;
   logic [DATA_W-1:0] cur_value;
   logic [REG_AW-1:0] cur_reg;
   logic              cur_load, cur_store, cur_wr;
   logic              wb_we;
   logic [DATA_W-1:0] mem_rdata;

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid && in_ready;

   // The operation completing this cycle comes straight off the bus when it
   // finishes at acceptance, otherwise from the latched request.
   always_comb begin
      cur_idx   = req_idx;
      cur_value = req_value;
      cur_reg   = req_reg;
      cur_load  = req_is_load;
      cur_store = req_is_store;
      cur_wr    = req_wr;
      done      = 1'b0;
      if (state_q == MEM) begin
         cur_idx   = idx_q;
         cur_value = value_q;
         cur_reg   = reg_q;
         cur_load  = load_q;
         cur_store = store_q;
         cur_wr    = wr_q;
         done      = (cnt_q == LAT_W'(1));
      end else if (accept) begin
         done = !req_is_mem || (MEM_LATENCY == 1);
      end
   end

   mawb_data_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (done && cur_store),
      .addr  (cur_idx),
      .wdata (cur_value),
      .rdata (mem_rdata)
   );

   assign wb_we = cur_wr && !cur_store && !((ZERO_REG != 0) && (cur_reg == '0));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      value_d      = value_q;
      reg_d        = reg_q;
      load_d       = load_q;
      store_d      = store_q;
      wr_d         = wr_q;
      rf_we_d      = 1'b0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      pend_valid_d = 1'b0;
      pend_addr_d  = pend_addr_q;
      err_d        = err_q;
      retired_d    = retired_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d   = req_idx;
               value_d = req_value;
               reg_d   = req_reg;
               load_d  = req_is_load;
               store_d = req_is_store;
               wr_d    = req_wr;
               if (req_load && req_memw) begin
                  err_d = 1'b1;
               end
               if (req_is_load && req_wr) begin
                  pend_valid_d = 1'b1;
                  pend_addr_d  = req_reg;
               end
               if (req_is_mem && (MEM_LATENCY > 1)) begin
                  state_d = MEM;
                  cnt_d   = LAT_W'(MEM_LATENCY - 1);
               end
            end
         end
         MEM: begin
            // Pending stays up through the write-back cycle after completion.
            pend_valid_d = pend_valid_q;
            cnt_d        = cnt_q - LAT_W'(1);
            if (cnt_q == LAT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (done) begin
         rf_we_d   = wb_we;
         retired_d = retired_q + CNT_W'(1);
         if (!cur_store) begin
            rf_waddr_d = cur_reg;
            rf_wdata_d = cur_load ? mem_rdata : cur_value;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         value_q      <= '0;
         reg_q        <= '0;
         load_q       <= 1'b0;
         store_q      <= 1'b0;
         wr_q         <= 1'b0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         err_q        <= 1'b0;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         value_q      <= value_d;
         reg_q        <= reg_d;
         load_q       <= load_d;
         store_q      <= store_d;
         wr_q         <= wr_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         err_q        <= err_d;
         retired_q    <= retired_d;
      end
   end

   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign pend_valid = pend_valid_q;
   assign pend_addr  = pend_addr_q;
   assign err        = err_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances (latency 1 defaults; latency 3 with
// DEPTH=16 and ZERO_REG=1; latency 4) driven by vectors and short sequences.
module tb_mem_wb_stage;

   localparam int BW = 79;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a, rst_b, rst_c;
   logic          val_a, val_b, val_c;
   logic [BW-1:0] bus_a, bus_b, bus_c;
   logic          rdy_a, rdy_b, rdy_c;
   logic          we_a, we_b, we_c;
   logic [3:0]    wa_a, wa_b, wa_c;
   logic [63:0]   wd_a, wd_b, wd_c;
   logic          pv_a, pv_b, pv_c;
   logic [3:0]    pa_a, pa_b, pa_c;
   logic          err_a, err_b, err_c;
   logic [15:0]   ret_a, ret_b, ret_c;

   mem_wb_stage u_a (
      .clk(clk), .rst(rst_a), .in_bus(bus_a), .in_valid(val_a), .in_ready(rdy_a),
      .rf_we(we_a), .rf_waddr(wa_a), .rf_wdata(wd_a), .pend_valid(pv_a),
      .pend_addr(pa_a), .err(err_a), .retired(ret_a)
   );

   mem_wb_stage #(.MEM_LATENCY(3), .DEPTH(16), .ZERO_REG(1)) u_b (
      .clk(clk), .rst(rst_b), .in_bus(bus_b), .in_valid(val_b), .in_ready(rdy_b),
      .rf_we(we_b), .rf_waddr(wa_b), .rf_wdata(wd_b), .pend_valid(pv_b),
      .pend_addr(pa_b), .err(err_b), .retired(ret_b)
   );

   mem_wb_stage #(.MEM_LATENCY(4)) u_c (
      .clk(clk), .rst(rst_c), .in_bus(bus_c), .in_valid(val_c), .in_ready(rdy_c),
      .rf_we(we_c), .rf_waddr(wa_c), .rf_wdata(wd_c), .pend_valid(pv_c),
      .pend_addr(pa_c), .err(err_c), .retired(ret_c)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          valid;
      logic [BW-1:0] bus;
      logic          we;
      logic [3:0]    waddr;
      logic [63:0]   wdata;
      logic          pend;
      logic [3:0]    paddr;
      logic [15:0]   ret;
      logic          err;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] mk(input logic [7:0] a, input logic [63:0] v,
                                        input logic [3:0] r, input logic ld,
                                        input logic mw, input logic wr);
      return {wr, mw, ld, r, v, a};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic b_issue(input logic [BW-1:0] bus, output int pulses,
                          output logic [3:0] wa, output logic [63:0] wd);
      int k;
      k = 0;
      while (!rdy_b && k < 20) begin
         step();
         k++;
      end
      check("b_ready_wait", {63'd0, rdy_b}, 64'd1);
      val_b = 1'b1;
      bus_b = bus;
      step();
      val_b  = 1'b0;
      pulses = 0;
      wa     = '0;
      wd     = '0;
      for (int j = 0; j < 6; j++) begin
         if (we_b) begin
            pulses++;
            wa = wa_b;
            wd = wd_b;
         end
         step();
      end
   endtask

   initial begin
      int          np;
      logic [3:0]  got_wa;
      logic [63:0] got_wd;

      vecs[0]  = '{1'b1, mk(8'h11, 64'd5, 4'd6, 0, 0, 1), 1'b1, 4'd6, 64'd5, 1'b0, 4'd0, 16'd1, 1'b0};
      vecs[1]  = '{1'b1, mk(8'h00, 64'd9, 4'd3, 0, 0, 0), 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 16'd2, 1'b0};
      vecs[2]  = '{1'b1, mk(8'h20, 64'hDEADBEEF, 4'd1, 0, 1, 1), 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 16'd3, 1'b0};
      vecs[3]  = '{1'b1, mk(8'h20, 64'd0, 4'd9, 1, 0, 1), 1'b1, 4'd9, 64'hDEADBEEF, 1'b1, 4'd9, 16'd4, 1'b0};
      vecs[4]  = '{1'b0, mk(8'h00, 64'd0, 4'd0, 0, 0, 1), 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 16'd4, 1'b0};
      vecs[5]  = '{1'b1, mk(8'h21, 64'h123456789ABCDEF0, 4'd0, 0, 1, 0), 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 16'd5, 1'b0};
      vecs[6]  = '{1'b1, mk(8'h21, 64'd0, 4'd0, 1, 0, 1), 1'b1, 4'd0, 64'h123456789ABCDEF0, 1'b1, 4'd0, 16'd6, 1'b0};
      vecs[7]  = '{1'b1, mk(8'h05, 64'hFFFFFFFFFFFFFFFF, 4'd15, 0, 0, 1), 1'b1, 4'd15, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0, 16'd7, 1'b0};
      vecs[8]  = '{1'b1, mk(8'h20, 64'd0, 4'd2, 1, 0, 0), 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 16'd8, 1'b0};
      vecs[9]  = '{1'b1, mk(8'h20, 64'h77, 4'd4, 1, 1, 1), 1'b1, 4'd4, 64'hDEADBEEF, 1'b1, 4'd4, 16'd9, 1'b1};
      vecs[10] = '{1'b1, mk(8'h20, 64'd0, 4'd5, 1, 0, 1), 1'b1, 4'd5, 64'hDEADBEEF, 1'b1, 4'd5, 16'd10, 1'b1};
      vecs[11] = '{1'b0, mk(8'h00, 64'd0, 4'd0, 0, 0, 0), 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 16'd10, 1'b1};

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
      bus_a = '0;   bus_b = '0;   bus_c = '0;
      repeat (3) step();

      // Reset state
      check("rst_ready_a", {63'd0, rdy_a}, 64'd1);
      check("rst_we_a", {63'd0, we_a}, 64'd0);
      check("rst_waddr_a", {60'd0, wa_a}, 64'd0);
      check("rst_wdata_a", wd_a, 64'd0);
      check("rst_pend_a", {63'd0, pv_a}, 64'd0);
      check("rst_paddr_a", {60'd0, pa_a}, 64'd0);
      check("rst_err_a", {63'd0, err_a}, 64'd0);
      check("rst_ret_a", {48'd0, ret_a}, 64'd0);
      check("rst_ready_b", {63'd0, rdy_b}, 64'd1);
      check("rst_ready_c", {63'd0, rdy_c}, 64'd1);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      step();

      // Latency-1 vectors
      for (int i = 0; i < 12; i++) begin
         val_a = vecs[i].valid;
         bus_a = vecs[i].bus;
         step();
         check($sformatf("v%0d_we", i), {63'd0, we_a}, {63'd0, vecs[i].we});
         if (vecs[i].we) begin
            check($sformatf("v%0d_waddr", i), {60'd0, wa_a}, {60'd0, vecs[i].waddr});
            check($sformatf("v%0d_wdata", i), wd_a, vecs[i].wdata);
         end
         check($sformatf("v%0d_pend", i), {63'd0, pv_a}, {63'd0, vecs[i].pend});
         if (vecs[i].pend) begin
            check($sformatf("v%0d_paddr", i), {60'd0, pa_a}, {60'd0, vecs[i].paddr});
         end
         check($sformatf("v%0d_ret", i), {48'd0, ret_a}, {48'd0, vecs[i].ret});
         check($sformatf("v%0d_err", i), {63'd0, err_a}, {63'd0, vecs[i].err});
         check($sformatf("v%0d_ready", i), {63'd0, rdy_a}, 64'd1);
      end
      val_a = 1'b0;

      // Back-to-back ALU ops after a fresh reset
      rst_a = 1'b1;
      #2;
      check("b2b_rst_err", {63'd0, err_a}, 64'd0);
      check("b2b_rst_ret", {48'd0, ret_a}, 64'd0);
      rst_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         val_a = 1'b1;
         bus_a = mk(8'(i), 64'(100 + i), 4'(i), 0, 0, 1);
         step();
         check($sformatf("b2b%0d_we", i), {63'd0, we_a}, 64'd1);
         check($sformatf("b2b%0d_waddr", i), {60'd0, wa_a}, 64'(i));
         check($sformatf("b2b%0d_wdata", i), wd_a, 64'(100 + i));
         check($sformatf("b2b%0d_ret", i), {48'd0, ret_a}, 64'(i + 1));
      end
      val_a = 1'b0;
      step();
      check("b2b_end_we", {63'd0, we_a}, 64'd0);
      check("b2b_end_ret", {48'd0, ret_a}, 64'd10);

      // Latency 3: store then load, load request held while stalled
      val_b = 1'b1;
      bus_b = mk(8'h02, 64'd3, 4'd0, 0, 1, 1);
      step();
      bus_b = mk(8'h02, 64'd0, 4'd7, 1, 0, 1);
      check("l3_st_ready1", {63'd0, rdy_b}, 64'd0);
      check("l3_st_we1", {63'd0, we_b}, 64'd0);
      step();
      check("l3_st_ready2", {63'd0, rdy_b}, 64'd0);
      check("l3_st_we2", {63'd0, we_b}, 64'd0);
      check("l3_st_pend2", {63'd0, pv_b}, 64'd0);
      step();
      check("l3_st_ready3", {63'd0, rdy_b}, 64'd1);
      check("l3_st_we3", {63'd0, we_b}, 64'd0);
      check("l3_st_ret", {48'd0, ret_b}, 64'd1);
      step();
      val_b = 1'b0;
      check("l3_ld_ready1", {63'd0, rdy_b}, 64'd0);
      check("l3_ld_pend1", {63'd0, pv_b}, 64'd1);
      check("l3_ld_paddr1", {60'd0, pa_b}, 64'd7);
      check("l3_ld_we1", {63'd0, we_b}, 64'd0);
      step();
      check("l3_ld_pend2", {63'd0, pv_b}, 64'd1);
      check("l3_ld_we2", {63'd0, we_b}, 64'd0);
      step();
      check("l3_ld_we3", {63'd0, we_b}, 64'd1);
      check("l3_ld_waddr3", {60'd0, wa_b}, 64'd7);
      check("l3_ld_wdata3", wd_b, 64'd3);
      check("l3_ld_pend3", {63'd0, pv_b}, 64'd1);
      check("l3_ld_ret3", {48'd0, ret_b}, 64'd2);
      step();
      check("l3_ld_we4", {63'd0, we_b}, 64'd0);
      check("l3_ld_pend4", {63'd0, pv_b}, 64'd0);

      // DEPTH=16 wrap and ZERO_REG suppression
      b_issue(mk(8'h13, 64'hAB, 4'd1, 0, 1, 0), np, got_wa, got_wd);
      check("wrap_st_pulses", 64'(np), 64'd0);
      b_issue(mk(8'h03, 64'd0, 4'd8, 1, 0, 1), np, got_wa, got_wd);
      check("wrap_ld_pulses", 64'(np), 64'd1);
      check("wrap_ld_waddr", {60'd0, got_wa}, 64'd8);
      check("wrap_ld_wdata", got_wd, 64'hAB);
      b_issue(mk(8'h00, 64'h55, 4'd0, 0, 0, 1), np, got_wa, got_wd);
      check("zreg_pulses", 64'(np), 64'd0);
      check("zreg_ret", {48'd0, ret_b}, 64'd5);
      b_issue(mk(8'h00, 64'h66, 4'd1, 0, 0, 1), np, got_wa, got_wd);
      check("reg1_pulses", 64'(np), 64'd1);
      check("reg1_wdata", got_wd, 64'h66);
      check("reg1_ret", {48'd0, ret_b}, 64'd6);
      check("b_err", {63'd0, err_b}, 64'd0);

      // Latency 4: reset during a store drops it
      val_c = 1'b1;
      bus_c = mk(8'h40, 64'h55, 4'd0, 0, 1, 0);
      step();
      val_c = 1'b0;
      check("l4_st_ready", {63'd0, rdy_c}, 64'd0);
      repeat (3) step();
      check("l4_st_done_ready", {63'd0, rdy_c}, 64'd1);
      check("l4_st_done_ret", {48'd0, ret_c}, 64'd1);
      val_c = 1'b1;
      bus_c = mk(8'h40, 64'h99, 4'd0, 0, 1, 0);
      step();
      val_c = 1'b0;
      step();
      check("l4_mid_ready", {63'd0, rdy_c}, 64'd0);
      #2;
      rst_c = 1'b1;
      #1;
      check("l4_rst_ready", {63'd0, rdy_c}, 64'd1);
      check("l4_rst_pend", {63'd0, pv_c}, 64'd0);
      check("l4_rst_ret", {48'd0, ret_c}, 64'd0);
      check("l4_rst_we", {63'd0, we_c}, 64'd0);
      #1;
      rst_c = 1'b0;
      val_c = 1'b1;
      bus_c = mk(8'h40, 64'd0, 4'd3, 1, 0, 1);
      step();
      val_c = 1'b0;
      check("l4_ld_pend1", {63'd0, pv_c}, 64'd1);
      check("l4_ld_paddr1", {60'd0, pa_c}, 64'd3);
      check("l4_ld_we1", {63'd0, we_c}, 64'd0);
      step();
      step();
      check("l4_ld_we3", {63'd0, we_c}, 64'd0);
      check("l4_ld_pend3", {63'd0, pv_c}, 64'd1);
      step();
      check("l4_ld_we4", {63'd0, we_c}, 64'd1);
      check("l4_ld_waddr4", {60'd0, wa_c}, 64'd3);
      check("l4_ld_wdata4", wd_c, 64'h55);
      check("l4_ld_ret4", {48'd0, ret_c}, 64'd1);
      check("l4_ld_pend4", {63'd0, pv_c}, 64'd1);
      step();
      check("l4_ld_we5", {63'd0, we_c}, 64'd0);
      check("l4_ld_pend5", {63'd0, pv_c}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
